mem_port_arbiter: RTL



---
 rtl/arbiter_types.sv | 20 ++
 rtl/mem_port_arbiter.sv | 100 ++++++++++
 2 files changed

// File: rtl/arbiter_types.sv
// rtl/arbiter_types.sv - shared types for the two-client memory port arbiter
package arbiter_types;

  localparam int ARB_ADDR_W = 32;
  localparam int ARB_DATA_W = 32;

  typedef enum logic [1:0] {
    ARB_IDLE = 2'd0,
    ARB_INST = 2'd1,
    ARB_DATA = 2'd2
  } arb_state_t;

  typedef struct packed {
    logic                    is_write;
    logic [ARB_ADDR_W-1:0]   addr;
    logic [ARB_DATA_W-1:0]   wdata;
    logic [ARB_DATA_W/8-1:0] mbe;
  } arb_req_t;

endpackage

// File: rtl/mem_port_arbiter.sv
// rtl/mem_port_arbiter.sv - round-robin merge of fetch and data ports onto one memory port
module mem_port_arbiter
  import arbiter_types::*;
#(
  parameter int ADDR_W = ARB_ADDR_W,
  parameter int DATA_W = ARB_DATA_W
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                inst_read,
  input  logic [ADDR_W-1:0]   inst_addr,
  output logic                inst_resp,
  output logic [DATA_W-1:0]   inst_rdata,
  input  logic                data_read,
  input  logic                data_write,
  input  logic [DATA_W/8-1:0] data_mbe,
  input  logic [ADDR_W-1:0]   data_addr,
  input  logic [DATA_W-1:0]   data_wdata,
  output logic                data_resp,
  output logic [DATA_W-1:0]   data_rdata,
  output logic                mem_read,
  output logic                mem_write,
  output logic [ADDR_W-1:0]   mem_addr,
  output logic [DATA_W-1:0]   mem_wdata,
  output logic [DATA_W/8-1:0] mem_mbe,
  input  logic                mem_resp,
  input  logic [DATA_W-1:0]   mem_rdata
);

  arb_state_t state;
  logic       last_data;
  arb_req_t   req;

  logic       grant_inst;
  logic       grant_data;
  arb_req_t   inst_req;
  arb_req_t   data_req;

  // Data wins a tie unless it won the previous grant.
  always_comb begin
    grant_inst = 1'b0;
    grant_data = 1'b0;
    if ((data_read | data_write) && !(inst_read && last_data))
      grant_data = 1'b1;
    else if (inst_read)
      grant_inst = 1'b1;

    inst_req          = '0;
    inst_req.is_write = 1'b0;
    inst_req.addr     = inst_addr;
    inst_req.wdata    = '0;
    inst_req.mbe      = '1;

    data_req          = '0;
    data_req.is_write = data_write;
    data_req.addr     = data_addr;
    data_req.wdata    = data_wdata;
    data_req.mbe      = data_mbe;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= ARB_IDLE;
      last_data <= 1'b0;
      req       <= '0;
    end else begin
      case (state)
        ARB_IDLE: begin
          if (grant_data) begin
            state     <= ARB_DATA;
            last_data <= 1'b1;
            req       <= data_req;
          end else if (grant_inst) begin
            state     <= ARB_INST;
            last_data <= 1'b0;
            req       <= inst_req;
          end
        end
        ARB_INST, ARB_DATA: begin
          if (mem_resp)
            state <= ARB_IDLE;
        end
        default: state <= ARB_IDLE;
      endcase
    end
  end

  assign mem_read   = (state != ARB_IDLE) && !req.is_write;
  assign mem_write  = (state != ARB_IDLE) &&  req.is_write;
  assign mem_addr   = req.addr;
  assign mem_wdata  = req.wdata;
  assign mem_mbe    = req.mbe;

  // Responses are steered by the latched owner, not by the live request lines.
  assign inst_resp  = (state == ARB_INST) && mem_resp;
  assign data_resp  = (state == ARB_DATA) && mem_resp;
  assign inst_rdata = inst_resp ? mem_rdata : '0;
  assign data_rdata = data_resp ? mem_rdata : '0;

endmodule
